// File: rtl/tutankham_pkg.sv
// Shared types and constants for the Tutankham ROM download sequencer.
// Index values follow the MiSTer ioctl numbering used by the core's .mra file.
package tutankham_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOADING,
      HOLD,
      RUN
   } load_state_t;

   localparam logic [7:0] IDX_CPU = 8'd0;
   localparam logic [7:0] IDX_SND = 8'd1;
   localparam int         CNT_W   = 16;

   function automatic logic is_rom_index(input logic [7:0] idx);
      return (idx == IDX_CPU) || (idx == IDX_SND);
   endfunction

endpackage

// File: rtl/rom_load_sequencer_counter.sv
// Saturating byte counter for one ROM index; flags when exactly LIMIT bytes were taken.
// A clear coinciding with an increment restarts the count at one.
module load_byte_counter
   import tutankham_pkg::*;
#(
   parameter int LIMIT = 8192
)
(
   input  logic clk_49m,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic full
);

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
   localparam logic [CNT_W-1:0] MAX_C   = '1;
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk_49m) begin
      if (reset) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= inc ? ONE_C : '0;
      end else if (inc && (count_reg != MAX_C)) begin
         count_reg <= count_reg + ONE_C;
      end
   end

   assign full = (count_reg == LIMIT_C);

endmodule

// File: rtl/rom_load_sequencer.sv
// Routes HPS ioctl ROM writes to the main and sound boards and keeps both boards
// in reset until every ROM set is complete and a settle delay has elapsed.
module rom_load_sequencer
   import tutankham_pkg::*;
#(
   parameter int CPU_ROM_BYTES = 61440,
   parameter int SND_ROM_BYTES = 8192,
   parameter int HOLD_CYCLES   = 1024
)
(
   input  logic        clk_49m,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic [24:0] ioctl_addr,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_data,
   output logic        cpu_wr,
   output logic        snd_wr,
   output logic [15:0] rom_addr,
   output logic [7:0]  rom_data,
   output logic        board_reset,
   output logic        load_done,
   output logic        load_error
);

   localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [24:0]       CPU_LIM   = 25'(CPU_ROM_BYTES);
   localparam logic [24:0]       SND_LIM   = 25'(SND_ROM_BYTES);

   load_state_t       state_reg;
   logic [HOLD_W-1:0] hold_reg;
   logic              cur_snd_reg;
   logic              cpu_tried_reg;
   logic              snd_tried_reg;
   logic              error_reg;
   logic              cpu_wr_reg;
   logic              snd_wr_reg;
   logic [15:0]       rom_addr_reg;
   logic [7:0]        rom_data_reg;
   logic              board_reset_reg;
   logic              load_done_reg;

   logic       dl_valid;
   logic       idx_snd;
   logic       addr_ok;
   logic       wr_take;
   logic       wr_bad;
   logic       start_load;
   logic [1:0] clr_vec;
   logic [1:0] inc_vec;
   logic [1:0] full_vec;

   always_comb begin
      dl_valid = ioctl_download && is_rom_index(ioctl_index);
      idx_snd  = (ioctl_index == IDX_SND);
      addr_ok  = idx_snd ? (ioctl_addr < SND_LIM) : (ioctl_addr < CPU_LIM);
      wr_take  = dl_valid && ioctl_wr && addr_ok;
      wr_bad   = dl_valid && ioctl_wr && !addr_ok;
      // Switching index without dropping download is treated as a fresh download.
      start_load = dl_valid &&
                   ((state_reg == IDLE) || (state_reg == RUN) ||
                    ((state_reg == LOADING) && (idx_snd != cur_snd_reg)));
      clr_vec  = {start_load && idx_snd, start_load && !idx_snd};
      inc_vec  = {wr_take && idx_snd, wr_take && !idx_snd};
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         load_byte_counter #(
            .LIMIT ((gi == 0) ? CPU_ROM_BYTES : SND_ROM_BYTES)
         ) u_cnt (
            .clk_49m (clk_49m),
            .reset   (reset),
            .clr     (clr_vec[gi]),
            .inc     (inc_vec[gi]),
            .full    (full_vec[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk_49m) begin
      if (reset) begin
         state_reg       <= IDLE;
         hold_reg        <= '0;
         cur_snd_reg     <= 1'b0;
         cpu_tried_reg   <= 1'b0;
         snd_tried_reg   <= 1'b0;
         error_reg       <= 1'b0;
         cpu_wr_reg      <= 1'b0;
         snd_wr_reg      <= 1'b0;
         rom_addr_reg    <= '0;
         rom_data_reg    <= '0;
         board_reset_reg <= 1'b1;
         load_done_reg   <= 1'b0;
      end else begin
         cpu_wr_reg <= inc_vec[0];
         snd_wr_reg <= inc_vec[1];
         if (wr_take) begin
            rom_addr_reg <= ioctl_addr[15:0];
            rom_data_reg <= ioctl_data;
         end
         if (start_load) begin
            cur_snd_reg <= idx_snd;
            if (idx_snd) begin
               snd_tried_reg <= 1'b1;
            end else begin
               cpu_tried_reg <= 1'b1;
            end
         end
         if (wr_bad) begin
            error_reg <= 1'b1;
         end

         case (state_reg)
            IDLE: begin
               if (start_load) begin
                  state_reg       <= LOADING;
                  board_reset_reg <= 1'b1;
                  load_done_reg   <= 1'b0;
               end
            end
            LOADING: begin
               if (!ioctl_download) begin
                  if (full_vec == 2'b11) begin
                     state_reg <= HOLD;
                     hold_reg  <= HOLD_LOAD;
                     error_reg <= 1'b0;
                  end else begin
                     // A short set only counts as an error once both ROMs were offered.
                     state_reg <= IDLE;
                     if (cpu_tried_reg && snd_tried_reg) begin
                        error_reg <= 1'b1;
                     end
                  end
               end
            end
            HOLD: begin
               if (hold_reg == '0) begin
                  state_reg       <= RUN;
                  board_reset_reg <= 1'b0;
                  load_done_reg   <= 1'b1;
               end else begin
                  hold_reg <= hold_reg - HOLD_ONE;
               end
            end
            RUN: begin
               if (start_load) begin
                  state_reg       <= LOADING;
                  board_reset_reg <= 1'b1;
                  load_done_reg   <= 1'b0;
               end
            end
            default: begin
               state_reg       <= IDLE;
               board_reset_reg <= 1'b1;
               load_done_reg   <= 1'b0;
            end
         endcase
      end
   end

   assign cpu_wr      = cpu_wr_reg;
   assign snd_wr      = snd_wr_reg;
   assign rom_addr    = rom_addr_reg;
   assign rom_data    = rom_data_reg;
   assign board_reset = board_reset_reg;
   assign load_done   = load_done_reg;
   assign load_error  = error_reg;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Randomised download bench for rom_load_sequencer with a per-cycle reference model
// plus literal checks on the key scenarios (first byte, range errors, settle delay).
module tb_rom_load_sequencer;

   logic        clk_49m = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic [24:0] ioctl_addr = '0;
   logic        ioctl_wr = 1'b0;
   logic [7:0]  ioctl_data = '0;
   logic        cpu_wr, snd_wr, board_reset, load_done, load_error;
   logic [15:0] rom_addr;
   logic [7:0]  rom_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #10 clk_49m = ~clk_49m;

   rom_load_sequencer dut (
      .clk_49m        (clk_49m),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_addr     (ioctl_addr),
      .ioctl_wr       (ioctl_wr),
      .ioctl_data     (ioctl_data),
      .cpu_wr         (cpu_wr),
      .snd_wr         (snd_wr),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .board_reset    (board_reset),
      .load_done      (load_done),
      .load_error     (load_error)
   );

   // ---------------- reference model ----------------
   localparam int P_IDLE = 0, P_LOADING = 1, P_HOLD = 2, P_RUN = 3;
   int          m_phase = P_IDLE;
   int          m_cnt [2];
   bit          m_tried [2];
   int          m_lim [2] = '{61440, 8192};
   int          m_act = 0;
   int          m_cyc = 0;
   int          m_hold_start = 0;
   bit          m_live = 1'b0;
   bit          m_valid;
   int          m_i;
   logic        e_cpu_wr, e_snd_wr, e_board_reset, e_load_done, e_load_error;
   logic [15:0] e_rom_addr;
   logic [7:0]  e_rom_data;

   always @(posedge clk_49m) begin
      m_cyc++;
      m_live = 1'b1;
      if (reset) begin
         m_phase = P_IDLE; m_cnt[0] = 0; m_cnt[1] = 0;
         m_tried[0] = 0; m_tried[1] = 0; m_act = 0;
         e_cpu_wr = 0; e_snd_wr = 0; e_rom_addr = 0; e_rom_data = 0;
         e_load_error = 0;
      end else begin
         m_valid = ioctl_download && (ioctl_index == 8'd0 || ioctl_index == 8'd1);
         m_i = (ioctl_index == 8'd1) ? 1 : 0;
         e_cpu_wr = 0;
         e_snd_wr = 0;
         if (m_valid && (m_phase == P_IDLE || m_phase == P_RUN ||
                         (m_phase == P_LOADING && m_i != m_act))) begin
            m_cnt[m_i] = 0;
            m_tried[m_i] = 1;
            m_act = m_i;
            m_phase = P_LOADING;
         end
         if (m_valid && ioctl_wr) begin
            if (int'(ioctl_addr) < m_lim[m_i]) begin
               if (m_cnt[m_i] < 65535) m_cnt[m_i]++;
               if (m_i == 0) e_cpu_wr = 1; else e_snd_wr = 1;
               e_rom_addr = ioctl_addr[15:0];
               e_rom_data = ioctl_data;
            end else begin
               e_load_error = 1;
            end
         end
         if (m_phase == P_LOADING && !ioctl_download) begin
            if (m_cnt[0] == m_lim[0] && m_cnt[1] == m_lim[1]) begin
               m_phase = P_HOLD;
               m_hold_start = m_cyc;
               e_load_error = 0;
            end else begin
               m_phase = P_IDLE;
               if (m_tried[0] && m_tried[1]) e_load_error = 1;
            end
         end else if (m_phase == P_HOLD && m_cyc == m_hold_start + 1024) begin
            m_phase = P_RUN;
         end
      end
      e_board_reset = (m_phase != P_RUN);
      e_load_done   = (m_phase == P_RUN);
   end

   always @(negedge clk_49m) begin
      if (m_live) begin
         n_checks++;
         if ({cpu_wr, snd_wr, rom_addr, rom_data, board_reset, load_done, load_error} !==
             {e_cpu_wr, e_snd_wr, e_rom_addr, e_rom_data, e_board_reset, e_load_done, e_load_error}) begin
            n_fail++;
            $display("FAIL model_cmp cyc=%0d: got cw=%b sw=%b a=%h d=%h br=%b ld=%b le=%b expected cw=%b sw=%b a=%h d=%h br=%b ld=%b le=%b",
                     m_cyc, cpu_wr, snd_wr, rom_addr, rom_data, board_reset, load_done, load_error,
                     e_cpu_wr, e_snd_wr, e_rom_addr, e_rom_data, e_board_reset, e_load_done, e_load_error);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk_49m);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic load_bytes(input int idx, input int first, input int n, input int gap_pct);
      ioctl_download = 1'b1;
      ioctl_index = 8'(idx);
      for (int a = first; a < first + n; a++) begin
         if (int'($urandom_range(99)) < gap_pct) begin
            ioctl_wr = 1'b0;
            cyc();
         end
         ioctl_wr = 1'b1;
         ioctl_addr = 25'(a);
         ioctl_data = 8'($urandom);
         cyc();
      end
      ioctl_wr = 1'b0;
   endtask

   task automatic end_download();
      ioctl_download = 1'b0;
      ioctl_wr = 1'b0;
      cyc();
   endtask

   task automatic measure_settle(input string name);
      int n = 0;
      end_download();
      while (board_reset === 1'b1 && n < 2000) begin
         cyc();
         n++;
      end
      chk(name, n, 1024);
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) cyc();
      chk("reset_board_reset", board_reset, 1);
      chk("reset_load_done", load_done, 0);
      chk("reset_wr", {cpu_wr, snd_wr}, 0);
      chk("reset_load_error", load_error, 0);
      chk("reset_rom_addr", rom_addr, 0);
      reset = 1'b0;
      cyc();

      // foreign index: no writes, no state change
      ioctl_download = 1'b1; ioctl_index = 8'd2;
      for (int a = 0; a < 8; a++) begin
         ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_data = 8'($urandom);
         cyc();
         chk("idx2_no_wr", {cpu_wr, snd_wr}, 0);
      end
      end_download();
      chk("idx2_board_reset", board_reset, 1);

      // short cpu load with the literal 0x1234 byte at the end
      load_bytes(0, 0, 4096, 0);
      ioctl_wr = 1'b1; ioctl_addr = 25'h1234; ioctl_data = 8'hA5;
      cyc();
      chk("lit_cpu_wr", cpu_wr, 1);
      chk("lit_snd_wr", snd_wr, 0);
      chk("lit_rom_addr", rom_addr, 16'h1234);
      chk("lit_rom_data", rom_data, 8'hA5);
      end_download();
      repeat (3) cyc();
      chk("short_board_reset", board_reset, 1);
      chk("short_load_error", load_error, 0);

      // sound load opening with an out-of-range byte on the rising edge
      ioctl_download = 1'b1; ioctl_index = 8'd1;
      ioctl_wr = 1'b1; ioctl_addr = 25'h2000; ioctl_data = 8'h5A;
      cyc();
      chk("oor_snd_wr", snd_wr, 0);
      chk("oor_load_error", load_error, 1);
      load_bytes(1, 0, 8192, 10);
      end_download();
      chk("snd_then_idle_br", board_reset, 1);

      // full cpu load completes the set
      load_bytes(0, 0, 61440, 0);
      measure_settle("settle_first");
      chk("first_load_done", load_done, 1);
      chk("first_load_error", load_error, 0);

      // foreign index while running
      ioctl_download = 1'b1; ioctl_index = 8'd7;
      for (int a = 0; a < 4; a++) begin
         ioctl_wr = 1'b1; ioctl_addr = 25'(a);
         cyc();
      end
      end_download();
      chk("run_idx7_load_done", load_done, 1);

      // sound reload from RUN, first byte on the rising edge
      ioctl_download = 1'b1; ioctl_index = 8'd1;
      ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_data = 8'h3C;
      cyc();
      chk("reload_board_reset", board_reset, 1);
      chk("reload_load_done", load_done, 0);
      chk("reload_first_snd_wr", snd_wr, 1);
      load_bytes(1, 1, 8191, 10);
      measure_settle("settle_reload");
      chk("reload_done", load_done, 1);

      // reset in the middle of a load drops the in-flight write
      ioctl_download = 1'b1; ioctl_index = 8'd0;
      ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_data = 8'h11;
      cyc();
      chk("midload_cpu_wr", cpu_wr, 1);
      ioctl_addr = 25'd6; ioctl_data = 8'h22; reset = 1'b1;
      cyc();
      chk("midreset_cpu_wr", cpu_wr, 0);
      chk("midreset_board_reset", board_reset, 1);
      chk("midreset_rom_addr", rom_addr, 0);
      reset = 1'b0;
      end_download();
      repeat (4) cyc();
      chk("after_reset_load_done", load_done, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
